pipelined_decode_unit: RTL

Registered, handshaked instruction-decode stage sitting between the instruction-fetch register and the execute stage of the CPU. It accepts one 32-bit instruction per cycle, decodes the opcode field into the datapath control word, and splits out register addresses and immediate/offset fields. It adds separate BEQ/JUMP outputs, valid/ready back-pressure from the data-memory busywait, a branch flush, an optional load-use interlock, and a saturating stall counter.

---
 rtl/pipelined_decode_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_decode_unit.sv
// pipelined_decode_unit: registered valid/ready decode stage with flush.
// Load-use interlock and STALL_COUNT exist only with PIPELINED_DECODE_HAZARD_EN.
module pipelined_decode_unit #(
    parameter int INSTR_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [INSTR_WIDTH-1:0]    INSTRUCTION,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic                      OUT_READY,
    input  logic                      FLUSH,
    output logic                      OUT_VALID,
    output logic                      WRITEENABLE,
    output logic                      ALUSRC,
    output logic                      SIGNEXT,
    output logic                      BEQ,
    output logic                      JUMP,
    output logic                      MEMREAD,
    output logic                      MEMWRITE,
    output logic                      MEMTOREG,
    output logic [2:0]                ALUOP,
    output logic [REG_ADDR_WIDTH-1:0] DEST_ADDR,
    output logic [REG_ADDR_WIDTH-1:0] SRC1_ADDR,
    output logic [REG_ADDR_WIDTH-1:0] SRC2_ADDR,
    output logic [7:0]                IMMEDIATE,
    output logic [7:0]                OFFSET,
    output logic [CNT_WIDTH-1:0]      STALL_COUNT
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_VALID,
        ST_BUBBLE
    } state_t;

    typedef struct packed {
        logic       we;
        logic       alusrc;
        logic       signext;
        logic       beq;
        logic       jump;
        logic       memrd;
        logic       memwr;
        logic [2:0] aluop;
    } ctrl_t;

    state_t                    state_q, state_d;
    ctrl_t                     ctrl_q, ctrl_d, dec_ctrl;
    logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [REG_ADDR_WIDTH-1:0] src1_q, src1_d;
    logic [REG_ADDR_WIDTH-1:0] src2_q, src2_d;
    logic [7:0]                imm_q, imm_d;
    logic [7:0]                off_q, off_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

    logic [7:0] op, dst_b, s1_b, s2_b;
    logic       hazard, stall, accept;
    logic       unused;

    assign op    = INSTRUCTION[INSTR_WIDTH-1  -: 8];
    assign dst_b = INSTRUCTION[INSTR_WIDTH-9  -: 8];
    assign s1_b  = INSTRUCTION[INSTR_WIDTH-17 -: 8];
    assign s2_b  = INSTRUCTION[INSTR_WIDTH-25 -: 8];
    assign unused = &{1'b0, s1_b[7:REG_ADDR_WIDTH]};

    always_comb begin
        dec_ctrl         = '0;
        dec_ctrl.we      = op[5];
        dec_ctrl.signext = op[4];
        dec_ctrl.alusrc  = op[3];
        dec_ctrl.aluop   = op[2:0];
        dec_ctrl.beq     = op[7] & op[6] & ~op[5];
        dec_ctrl.jump    = ~op[7] & op[6] & ~op[5];
        dec_ctrl.memrd   = op[5] & ~op[6];
        dec_ctrl.memwr   = ~(op[6] | op[5] | op[4]);
    end

    assign OUT_VALID = (state_q == ST_VALID);
    assign stall     = OUT_VALID & ~OUT_READY;

`ifdef PIPELINED_DECODE_HAZARD_EN
    // Incoming src2 only matters when it is a register, not an immediate.
    assign hazard = OUT_VALID & ctrl_q.memrd & ctrl_q.we & IN_VALID &
                    ((dest_q == s1_b[REG_ADDR_WIDTH-1:0]) |
                     ((dest_q == s2_b[REG_ADDR_WIDTH-1:0]) & ~op[3]));
`else
    assign hazard = 1'b0;
`endif

    assign IN_READY = ~FLUSH & ~hazard & (~OUT_VALID | OUT_READY);
    assign accept   = IN_VALID & IN_READY;

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        dest_d  = dest_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        imm_d   = imm_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        if (FLUSH) begin
            state_d = ST_EMPTY;
            ctrl_d  = '0;
        end else if (!stall) begin
            if (hazard) begin
                state_d = ST_BUBBLE;
                ctrl_d  = '0;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else if (accept) begin
                state_d = ST_VALID;
                ctrl_d  = dec_ctrl;
                dest_d  = dst_b[REG_ADDR_WIDTH-1:0];
                src1_d  = s1_b[REG_ADDR_WIDTH-1:0];
                src2_d  = s2_b[REG_ADDR_WIDTH-1:0];
                imm_d   = s2_b;
                off_d   = dst_b;
            end else begin
                state_d = ST_EMPTY;
                ctrl_d  = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_EMPTY;
            ctrl_q  <= '0;
            dest_q  <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            imm_q   <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            dest_q  <= dest_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            imm_q   <= imm_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
        end
    end

    assign WRITEENABLE = ctrl_q.we;
    assign ALUSRC      = ctrl_q.alusrc;
    assign SIGNEXT     = ctrl_q.signext;
    assign BEQ         = ctrl_q.beq;
    assign JUMP        = ctrl_q.jump;
    assign MEMREAD     = ctrl_q.memrd;
    assign MEMTOREG    = ctrl_q.memrd;
    assign MEMWRITE    = ctrl_q.memwr;
    assign ALUOP       = ctrl_q.aluop;
    assign DEST_ADDR   = dest_q;
    assign SRC1_ADDR   = src1_q;
    assign SRC2_ADDR   = src2_q;
    assign IMMEDIATE   = imm_q;
    assign OFFSET      = off_q;
    assign STALL_COUNT = cnt_q;

endmodule
